// File: rtl/branch_pc_pkg.sv
// Shared encodings for the fetch PC / branch tag block: FSM states, reset PC,
// tag sizing and the circular kill-mask helper.
package branch_pc_pkg;
  localparam int          TAG_W    = 2;
  localparam int          NUM_TAGS = 1 << TAG_W;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [NUM_TAGS-1:0] tag_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Tags strictly younger than 'from' up to tail-1; tail==from means the ring is full.
  function automatic tag_mask_t kill_mask(tag_t from, tag_t tail);
    tag_t      span;
    tag_t      idx;
    tag_mask_t m;
    m    = '0;
    span = tail - from;
    for (int i = 1; i < NUM_TAGS; i++) begin
      idx = from + tag_t'(i);
      if (span == '0 || tag_t'(i) < span) m[idx] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/branch_pc_if.sv
// Fetch / decode / branch-unit signal bundle; master drives the block inputs.
interface branch_pc_if;
  import branch_pc_pkg::*;

  logic        fetchReady;
  logic        bAllocReq;
  logic        BranchResultEn;
  logic [31:0] BranchAddr;
  tag_t        bFreeNum;
  logic        misTaken;

  logic [31:0] PC;
  logic        fetchEn;
  tag_t        bAllocNum;
  logic        bAllocGnt;
  logic        bFull;
  logic        flush;
  tag_mask_t   flushMask;

  modport master (
    output fetchReady, bAllocReq, BranchResultEn, BranchAddr, bFreeNum, misTaken,
    input  PC, fetchEn, bAllocNum, bAllocGnt, bFull, flush, flushMask
  );

  modport slave (
    input  fetchReady, bAllocReq, BranchResultEn, BranchAddr, bFreeNum, misTaken,
    output PC, fetchEn, bAllocNum, bAllocGnt, bFull, flush, flushMask
  );
endinterface

// File: rtl/branch_tag_mgr.sv
// Branch tag ring: busy bitmap, tail allocation pointer, free and mispredict
// kill handling. Mispredict detection and kill mask are combinational.
module branch_tag_mgr
  import branch_pc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc_gnt_i,
  input  logic      result_en_i,
  input  logic      mis_taken_i,
  input  tag_t      free_tag_i,
  output tag_t      tail_o,
  output logic      full_o,
  output logic      mispredict_o,
  output tag_mask_t kill_mask_o
);
  tag_mask_t busy_q, busy_d;
  tag_t      tail_q, tail_d;

  assign tail_o       = tail_q;
  assign full_o       = busy_q[tail_q];
  assign mispredict_o = result_en_i & mis_taken_i & busy_q[free_tag_i];
  assign kill_mask_o  = mispredict_o ? kill_mask(free_tag_i, tail_q) : '0;

  always_comb begin
    busy_d = busy_q;
    tail_d = tail_q;
    if (mispredict_o) begin
      // Rewind the ring to just after the mispredicted branch.
      busy_d             = busy_q & ~kill_mask_o;
      busy_d[free_tag_i] = 1'b0;
      tail_d             = free_tag_i + tag_t'(1);
    end else begin
      if (result_en_i && !mis_taken_i) busy_d[free_tag_i] = 1'b0;
      if (alloc_gnt_i) begin
        busy_d[tail_q] = 1'b1;
        tail_d         = tail_q + tag_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      tail_q <= '0;
    end else begin
      busy_q <= busy_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/branch_pc.sv
// Fetch PC sequencer with IDLE/RUN/FLUSH state machine; redirects on branch
// mispredict and gates tag grants from branch_tag_mgr.
module branch_pc
  import branch_pc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  branch_pc_if.slave  bus
);
  state_e      state_q;
  logic [31:0] pc_q;
  logic        fetch_en_q;

  tag_t        tail;
  logic        full;
  logic        mispredict;
  tag_mask_t   kill;
  logic        alloc_gnt;

  assign alloc_gnt = bus.bAllocReq & ~full & (state_q == ST_RUN) & ~mispredict;

  branch_tag_mgr u_tag_mgr (
    .clk          (clk),
    .rst          (rst),
    .alloc_gnt_i  (alloc_gnt),
    .result_en_i  (bus.BranchResultEn),
    .mis_taken_i  (bus.misTaken),
    .free_tag_i   (bus.bFreeNum),
    .tail_o       (tail),
    .full_o       (full),
    .mispredict_o (mispredict),
    .kill_mask_o  (kill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_en_q <= 1'b0;
    end else if (mispredict) begin
      // Redirect beats any concurrent fetch accept.
      state_q    <= ST_FLUSH;
      pc_q       <= bus.BranchAddr;
      fetch_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_RUN;
          fetch_en_q <= 1'b1;
        end
        ST_RUN: begin
          if (bus.fetchReady) pc_q <= pc_q + 32'd4;
        end
        ST_FLUSH: begin
          state_q    <= ST_RUN;
          fetch_en_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          fetch_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC        = pc_q;
  assign bus.fetchEn   = fetch_en_q;
  assign bus.bAllocNum = tail;
  assign bus.bAllocGnt = alloc_gnt;
  assign bus.bFull     = full;
  assign bus.flush     = mispredict;
  assign bus.flushMask = kill;
endmodule

// File: tb/tb_branch_pc.sv
// Scoreboard bench for branch_pc: stimulus queues expected fetches, grants,
// flushes and port snapshots; a negedge monitor pops and compares.
module tb_branch_pc;
  import branch_pc_pkg::*;

  typedef struct {
    logic        fe;
    logic        full;
    tag_t        num;
    logic [31:0] pc;
  } snap_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   end_req  = 0;

  logic [31:0] exp_fetch[$];
  tag_t        exp_gnt[$];
  tag_mask_t   exp_flush[$];
  snap_t       exp_snap[$];

  logic [31:0] e_pc;
  tag_t        e_tag;
  tag_mask_t   e_mask;
  snap_t       e_snap;

  branch_pc_if bus();

  branch_pc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fetchEn && bus.fetchReady) begin
      checks++;
      if (exp_fetch.size() == 0) begin
        failures++;
        $display("FAIL fetch_unexpected actual_pc=%h required=none", bus.PC);
      end else begin
        e_pc = exp_fetch.pop_front();
        if (bus.PC !== e_pc) begin
          failures++;
          $display("FAIL fetch_pc actual=%h required=%h", bus.PC, e_pc);
        end
      end
    end
    if (bus.bAllocGnt) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected actual_tag=%0d required=none", bus.bAllocNum);
      end else begin
        e_tag = exp_gnt.pop_front();
        if (bus.bAllocNum !== e_tag) begin
          failures++;
          $display("FAIL grant_tag actual=%0d required=%0d", bus.bAllocNum, e_tag);
        end
      end
    end
    if (bus.flush) begin
      checks++;
      if (exp_flush.size() == 0) begin
        failures++;
        $display("FAIL flush_unexpected actual_mask=%b required=none", bus.flushMask);
      end else begin
        e_mask = exp_flush.pop_front();
        if (bus.flushMask !== e_mask) begin
          failures++;
          $display("FAIL flush_mask actual=%b required=%b", bus.flushMask, e_mask);
        end
      end
    end
    if (exp_snap.size() != 0) begin
      e_snap = exp_snap.pop_front();
      checks++;
      if (bus.fetchEn !== e_snap.fe || bus.bFull !== e_snap.full ||
          bus.bAllocNum !== e_snap.num || bus.PC !== e_snap.pc) begin
        failures++;
        $display("FAIL snapshot actual fe=%b full=%b num=%0d pc=%h required fe=%b full=%b num=%0d pc=%h",
                 bus.fetchEn, bus.bFull, bus.bAllocNum, bus.PC,
                 e_snap.fe, e_snap.full, e_snap.num, e_snap.pc);
      end
    end
    if (end_req == 1) begin
      checks++;
      if (exp_fetch.size() != 0 || exp_gnt.size() != 0 || exp_flush.size() != 0) begin
        failures++;
        $display("FAIL leftover actual fetch=%0d grant=%0d flush=%0d required all 0",
                 exp_fetch.size(), exp_gnt.size(), exp_flush.size());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic fe, input logic full, input tag_t num, input logic [31:0] pc);
    snap_t s;
    s.fe = fe; s.full = full; s.num = num; s.pc = pc;
    exp_snap.push_back(s);
  endtask

  task automatic result(input logic en, input logic mis, input tag_t tag, input logic [31:0] addr);
    bus.BranchResultEn = en;
    bus.misTaken       = mis;
    bus.bFreeNum       = tag;
    bus.BranchAddr     = addr;
  endtask

  initial begin
    rst                = 1'b1;
    bus.fetchReady     = 1'b0;
    bus.bAllocReq      = 1'b0;
    result(1'b0, 1'b0, 2'd0, 32'h0);
    #1 rst = 1'b0;
    step(); step();
    snap(1'b0, 1'b0, 2'd0, 32'h0);
    step();
    rst = 1'b1;

    // Startup: IDLE for one cycle, then sequential fetch.
    snap(1'b0, 1'b0, 2'd0, 32'h0);
    bus.fetchReady = 1'b1;
    foreach (exp_fetch[i]) ;
    for (int i = 0; i < 4; i++) exp_fetch.push_back(32'(i * 4));
    repeat (5) step();
    bus.fetchReady = 1'b0;

    // Fill all four tags, then stall on a full ring.
    for (int i = 0; i < 4; i++) exp_gnt.push_back(tag_t'(i));
    bus.bAllocReq = 1'b1;
    repeat (4) step();
    snap(1'b1, 1'b1, 2'd0, 32'd16);
    step();
    bus.bAllocReq = 1'b0;

    // Mispredict on tag 1 with the ring full.
    exp_flush.push_back(4'b1100);
    result(1'b1, 1'b1, 2'd1, 32'h100);
    step();
    result(1'b0, 1'b0, 2'd0, 32'h0);
    snap(1'b0, 1'b0, 2'd2, 32'h100);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    snap(1'b0, 1'b0, 2'd0, 32'h0);
    step();
    rst = 1'b1;

    // After reset-in-flush: fresh ring, allocate tags 0..2.
    for (int i = 0; i < 3; i++) exp_gnt.push_back(tag_t'(i));
    bus.bAllocReq = 1'b1;
    repeat (4) step();
    bus.bAllocReq = 1'b0;

    // Plain free of tag 2 while fetch advances from 0.
    exp_fetch.push_back(32'h0);
    exp_fetch.push_back(32'h4);
    bus.fetchReady = 1'b1;
    result(1'b1, 1'b0, 2'd2, 32'h0);
    step();
    result(1'b0, 1'b0, 2'd0, 32'h0);
    step();

    // Taken result for the now-free tag 2 must be ignored.
    bus.fetchReady = 1'b0;
    result(1'b1, 1'b1, 2'd2, 32'h300);
    snap(1'b1, 1'b0, 2'd3, 32'h8);
    step();
    result(1'b0, 1'b0, 2'd0, 32'h0);
    snap(1'b1, 1'b0, 2'd3, 32'h8);
    step();

    // Mispredict on tag 0 colliding with fetch accept and alloc request.
    exp_fetch.push_back(32'h8);
    exp_flush.push_back(4'b0110);
    bus.fetchReady = 1'b1;
    bus.bAllocReq  = 1'b1;
    result(1'b1, 1'b1, 2'd0, 32'h200);
    step();
    result(1'b0, 1'b0, 2'd0, 32'h0);
    bus.bAllocReq = 1'b0;
    snap(1'b0, 1'b0, 2'd1, 32'h200);
    exp_fetch.push_back(32'h200);
    exp_fetch.push_back(32'h204);
    step(); step(); step();
    bus.fetchReady = 1'b0;

    // Tail rewound to 1 with every tag free.
    exp_gnt.push_back(2'd1);
    bus.bAllocReq = 1'b1;
    step();
    bus.bAllocReq = 1'b0;

    repeat (3) step();
    end_req = 1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_pc.md
BRANCH_PC -- requirements
Module: branch_pc

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 fetchReady  in  1  instruction fetch accepts the current PC this cycle.
REQ-005 bAllocReq  in  1  decoder has a branch needing a tag this cycle.
REQ-006 BranchResultEn  in  1  branch unit result valid; also frees the tag.
REQ-007 BranchAddr  in  32  resolved next address of the branch.
REQ-008 bFreeNum  in  2  tag of the resolved branch.
REQ-009 misTaken  in  1  branch resolved taken, so the static not-taken prediction was wrong.
REQ-010 PC  out  32  current fetch address.
REQ-011 fetchEn  out  1  PC is valid for fetch.
REQ-012 bAllocNum  out  2  tag granted to the decoder, equal to the tail pointer.
REQ-013 bAllocGnt  out  1  tag granted this cycle.
REQ-014 bFull  out  1  no free tag at the tail; the decoder must stall.
REQ-015 flush  out  1  one-cycle pulse that kills younger in-flight work.
REQ-016 flushMask  out  4  tags killed by flush, one-hot per tag.

Function
REQ-017 State machine states:
- IDLE: entered by reset.
- RUN: normal fetch.
- FLUSH: redirect cycle.
- IDLE->RUN unconditionally on the first clock after reset.
REQ-018 fetchEn SHALL be 1 only in RUN; in IDLE and FLUSH it SHALL be 0.
REQ-019 In RUN, when fetchEn and fetchReady are both 1 and no mispredict occurs, PC SHALL advance to PC+4 next cycle, wrapping modulo 2^32.
REQ-020 Tag state: 4-entry busy bitmap plus a 2-bit tail pointer; tags are allocated only at the tail.
REQ-021 bFull SHALL equal busy[tail], evaluated on the registered bitmap.
REQ-022 Grant condition: bAllocGnt = bAllocReq and not bFull and state RUN and no mispredict this cycle.
REQ-023 On a grant, busy[tail] SHALL be set and tail SHALL increment by 1, wrapping 3->0.
REQ-024 Plain free: BranchResultEn with misTaken=0 SHALL clear busy[bFreeNum] next cycle; PC is unaffected.
REQ-025 A mispredict is BranchResultEn=1, misTaken=1 and busy[bFreeNum]=1.
REQ-026 On a mispredict, in the same cycle:
- Kill set: tags bFreeNum+1 up to tail-1, circular, excluding bFreeNum.
- flush SHALL pulse 1 and flushMask SHALL equal the kill set.
- Next cycle: busy clears for bFreeNum and the kill set; tail becomes bFreeNum+1.
- Next cycle: PC becomes BranchAddr and state becomes FLUSH.
REQ-027 FLUSH SHALL return to RUN after exactly one cycle, with fetchEn then asserted at the redirected PC.
REQ-028 Simultaneous mispredict and fetch accept: the mispredict wins and the PC+4 update is discarded.
REQ-029 Simultaneous mispredict and bAllocReq: no grant is made.
REQ-030 A mispredict arriving in the FLUSH state SHALL be processed the same as in RUN.
REQ-031 A result whose tag is not busy SHALL be ignored: no flush and no state change.
REQ-032 Simultaneous grant and free of different tags SHALL both take effect in the same cycle.

Reset
REQ-033 While rst=0 the block SHALL hold:
- PC=0, busy=0000, tail=0, state=IDLE.
- fetchEn=0, flush=0, flushMask=0000.
- bAllocGnt=0, bAllocNum=0, bFull=0.
REQ-034 Reset asserted mid-flush SHALL immediately abort the redirect; on release, fetch restarts at address 0.

Structure
REQ-035 The state encodings, the reset PC value and the tag width (2) SHALL live in the shared defines package.
REQ-036 The tag bitmap, tail pointer and kill-mask generation SHALL form one sub-module, branch_tag_mgr; branch_pc holds the PC and the state machine.

Verification
REQ-037 Release reset, fetchReady=1 for 3 cycles -> PC goes 0,4,8,12 with fetchEn=1 from the second cycle after release.
REQ-038 Four bAllocReq with no results -> tags 0,1,2,3 granted; then bFull=1 and a fifth request is not granted.
REQ-039 Tags 0..3 busy, result tag1 misTaken=1 BranchAddr=0x100 -> flush=1, flushMask=1100; next cycle PC=0x100, FLUSH, busy=0001, tail=2.
REQ-040 Result tag2 misTaken=0 while tail=3 and busy=0111 -> busy=0011, no flush, PC keeps advancing.
REQ-041 Mispredict with BranchAddr=0x200 in the same cycle as fetchReady=1 and bAllocReq=1 -> PC=0x200, no grant, no PC+4.
REQ-042 Result for a non-busy tag with misTaken=1 -> no flush, PC unchanged; reset pulse during FLUSH -> PC=0, busy=0000.
